// File: rtl/bus_arbiter_rr4.sv
// bus_arbiter_rr4: round-robin arbiter sharing one data bus among four
// requesters. Grants are one-hot active-low. An owner keeps the bus while it
// requests, up to MAX_HOLD cycles when someone else is waiting. The granted
// requester's data is steered combinationally onto bus_data.
module bus_arbiter_rr4 #(
  parameter int WIDTH    = 10,
  parameter int MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [3:0]         req,
  input  logic [4*WIDTH-1:0] data_in,
  output logic [3:0]         grant_n,
  output logic [1:0]         grant_id,
  output logic               bus_valid,
  output logic [WIDTH-1:0]   bus_data
);

  // Hold counter is wide enough for MAX_HOLD-1 and never narrower than 1 bit.
  localparam int HCW = (MAX_HOLD <= 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HCW-1:0] HOLD_LAST = HCW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t         state_reg, state_next;
  logic [1:0]     owner_reg, owner_next;
  logic [1:0]     last_reg, last_next;
  logic [HCW-1:0] hold_reg, hold_next;
  logic [3:0]     grant_n_reg, grant_n_next;
  logic [1:0]     grant_id_reg, grant_id_next;
  logic           bus_valid_reg, bus_valid_next;

  logic [3:0]       owner_oh;
  logic [3:0]       pick_mask;
  logic [1:0]       pick_idx;
  logic             others_pending;
  logic [1:0]       cand [4];
  logic [WIDTH-1:0] data_slice [4];

  assign owner_oh       = 4'b0001 << owner_reg;
  assign others_pending = |(req & ~owner_oh);

  // While busy, the current owner is never a candidate for the next pick.
  assign pick_mask = (state_reg == BUSY) ? (req & ~owner_oh) : req;

  // Candidate order for the rotating pick: last+1, last+2, last+3, last+4.
  for (genvar gi = 0; gi < 4; gi++) begin : g_cand
    assign cand[gi] = last_reg + 2'(gi + 1);
  end

  // Per-requester data slices for the output mux.
  for (genvar gi = 0; gi < 4; gi++) begin : g_slice
    assign data_slice[gi] = data_in[gi*WIDTH +: WIDTH];
  end

  // Rotating pick: scan lowest priority first so the nearest candidate wins.
  always_comb begin
    pick_idx = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (pick_mask[cand[k]]) begin
        pick_idx = cand[k];
      end
    end
  end

  // Next-state logic: grant from idle, handoff on release, bounded-hold preemption.
  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    last_next  = last_reg;
    hold_next  = hold_reg;
    case (state_reg)
      IDLE: begin
        if (|req) begin
          state_next = BUSY;
          owner_next = pick_idx;
          last_next  = pick_idx;
          hold_next  = '0;
        end
      end
      BUSY: begin
        if (!req[owner_reg]) begin
          // Release: hand straight to the next requester, no bubble cycle.
          if (others_pending) begin
            owner_next = pick_idx;
            last_next  = pick_idx;
            hold_next  = '0;
          end else begin
            state_next = IDLE;
            hold_next  = '0;
          end
        end else if ((MAX_HOLD != 0) && (hold_reg == HOLD_LAST) && others_pending) begin
          // Hold budget used up and someone is waiting: preempt.
          owner_next = pick_idx;
          last_next  = pick_idx;
          hold_next  = '0;
        end else if (hold_reg != HOLD_LAST) begin
          // Saturating count so a lone owner is never wrapped back to zero.
          hold_next = hold_reg + HCW'(1);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output values derived from the next state so the outputs are plain flops.
  always_comb begin
    grant_n_next   = 4'b1111;
    grant_id_next  = 2'd0;
    bus_valid_next = 1'b0;
    if (state_next == BUSY) begin
      grant_n_next   = ~(4'b0001 << owner_next);
      grant_id_next  = owner_next;
      bus_valid_next = 1'b1;
    end
  end

  // State and output registers; reset clears outputs immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      owner_reg     <= 2'd0;
      last_reg      <= 2'd3;
      hold_reg      <= '0;
      grant_n_reg   <= 4'b1111;
      grant_id_reg  <= 2'd0;
      bus_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      owner_reg     <= owner_next;
      last_reg      <= last_next;
      hold_reg      <= hold_next;
      grant_n_reg   <= grant_n_next;
      grant_id_reg  <= grant_id_next;
      bus_valid_reg <= bus_valid_next;
    end
  end

  assign grant_n   = grant_n_reg;
  assign grant_id  = grant_id_reg;
  assign bus_valid = bus_valid_reg;
  assign bus_data  = bus_valid_reg ? data_slice[grant_id_reg] : '0;

endmodule

// File: tb/tb_bus_arbiter_rr4.sv
// Testbench for bus_arbiter_rr4: directed scenarios followed by randomized
// request traffic, all checked against a cycle-level behavioural model.
module tb_bus_arbiter_rr4;

  localparam int WIDTH    = 10;
  localparam int MAX_HOLD = 8;

  logic               clk;
  logic               reset_n;
  logic [3:0]         req;
  logic [4*WIDTH-1:0] data_in;
  logic [3:0]         grant_n;
  logic [1:0]         grant_id;
  logic               bus_valid;
  logic [WIDTH-1:0]   bus_data;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Behavioural model: who owns the bus, who was granted last, and how many
  // cycles the owner has held it so far.
  bit m_busy;
  int m_owner;
  int m_last;
  int m_held;

  bus_arbiter_rr4 #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req      (req),
    .data_in  (data_in),
    .grant_n  (grant_n),
    .grant_id (grant_id),
    .bus_valid(bus_valid),
    .bus_data (bus_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int model_pick(input logic [3:0] r, input int excl);
    for (int k = 1; k <= 4; k++) begin
      int idx;
      idx = (m_last + k) % 4;
      if (r[idx] && idx != excl) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy  = 1'b0;
    m_owner = 0;
    m_last  = 3;
    m_held  = 0;
  endtask

  // One rising edge of the reference arbiter, given the requests at that edge.
  task automatic model_edge(input logic [3:0] r);
    logic [3:0] others;
    int p;
    if (!m_busy) begin
      if (r != 4'b0000) begin
        p = model_pick(r, -1);
        m_busy = 1'b1; m_owner = p; m_last = p; m_held = 1;
      end
    end else begin
      others = r;
      others[m_owner] = 1'b0;
      if (!r[m_owner]) begin
        if (others != 4'b0000) begin
          p = model_pick(r, m_owner);
          m_owner = p; m_last = p; m_held = 1;
        end else begin
          m_busy = 1'b0;
        end
      end else if (MAX_HOLD != 0 && m_held >= MAX_HOLD && others != 4'b0000) begin
        p = model_pick(r, m_owner);
        m_owner = p; m_last = p; m_held = 1;
      end else begin
        m_held++;
      end
    end
  endtask

  task automatic check_model();
    logic [3:0]       e_gn;
    logic [1:0]       e_id;
    logic [WIDTH-1:0] e_data;
    e_gn   = 4'b1111;
    e_id   = 2'd0;
    e_data = '0;
    if (m_busy) begin
      e_gn[m_owner] = 1'b0;
      e_id   = 2'(m_owner);
      e_data = data_in[m_owner*WIDTH +: WIDTH];
    end
    check("grant_n", 32'(grant_n), 32'(e_gn));
    check("grant_id", 32'(grant_id), 32'(e_id));
    check("bus_valid", 32'(bus_valid), 32'(m_busy));
    check("bus_data", 32'(bus_data), 32'(e_data));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge(req);
    #1;
    cyc++;
    check_model();
    $display("cyc %0d req %b grant_n %b grant_id %0d bus_valid %b bus_data %h",
             cyc, req, grant_n, grant_id, bus_valid, bus_data);
  endtask

  // Asynchronous reset pulse placed between clock edges; checks that the
  // outputs clear without any clock edge.
  task automatic mid_reset(input logic [3:0] req_after);
    reset_n = 1'b0;
    #2;
    check("async_rst_grant_n", 32'(grant_n), 32'hF);
    check("async_rst_valid", 32'(bus_valid), 32'h0);
    check("async_rst_data", 32'(bus_data), 32'h0);
    model_reset();
    $display("cyc %0d async reset pulse", cyc);
    @(negedge clk);
    reset_n = 1'b1;
    req = req_after;
  endtask

  initial begin : stim
    int prev_id;
    int run;

    reset_n = 1'b0;
    req     = 4'b1111;
    for (int i = 0; i < 4; i++) data_in[i*WIDTH +: WIDTH] = WIDTH'(10'h100 + i);
    model_reset();

    // Reset held low with every requester active.
    repeat (2) @(negedge clk);
    check("rst_grant_n", 32'(grant_n), 32'hF);
    check("rst_valid", 32'(bus_valid), 32'h0);
    check("rst_data", 32'(bus_data), 32'h0);
    check("rst_grant_id", 32'(grant_id), 32'h0);
    reset_n = 1'b1;
    tick();
    check("first_grant_n", 32'(grant_n), 32'hE);
    check("first_grant_id", 32'(grant_id), 32'h0);

    // Rotation with all requesters active: each owner keeps the bus MAX_HOLD cycles.
    prev_id = 0;
    run     = 1;
    for (int t = 0; t < 40; t++) begin
      tick();
      check("rot_data", 32'(bus_data), 32'h100 + 32'(grant_id));
      if (int'(grant_id) == prev_id) begin
        run++;
      end else begin
        check("rot_hold_len", 32'(run), 32'(MAX_HOLD));
        check("rot_next_owner", 32'(grant_id), 32'((prev_id + 1) % 4));
        prev_id = int'(grant_id);
        run = 1;
      end
    end

    // No-bubble handoff from 0 to 2.
    req = 4'b0001; tick();
    req = 4'b0101; tick();
    check("nb_owner0", 32'(grant_id), 32'h0);
    req = 4'b0100; tick();
    check("nb_grant_n", 32'(grant_n), 32'hB);
    check("nb_grant_id", 32'(grant_id), 32'h2);
    check("nb_valid", 32'(bus_valid), 32'h1);

    // Lone requester is never preempted; a newcomer takes over one edge later.
    for (int t = 0; t < 20; t++) begin
      tick();
      check("lone_grant_n", 32'(grant_n), 32'hB);
    end
    req = 4'b0101; tick();
    check("lone_preempt_id", 32'(grant_id), 32'h0);

    // Mid-grant asynchronous reset, then requester 3 alone.
    mid_reset(4'b1000);
    tick();
    check("post_rst_id", 32'(grant_id), 32'h3);

    // Idle, then the pointer ordering from last = 3.
    req = 4'b0000; tick();
    check("idle_grant_n", 32'(grant_n), 32'hF);
    check("idle_valid", 32'(bus_valid), 32'h0);
    check("idle_data", 32'(bus_data), 32'h0);
    mid_reset(4'b1001);
    tick();
    check("ptr_first_id", 32'(grant_id), 32'h0);
    req = 4'b1000; tick();
    check("ptr_second_id", 32'(grant_id), 32'h3);

    // Randomized traffic: requests toggle occasionally, data changes every cycle.
    for (int t = 0; t < 2000; t++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(3) == 0) req[i] = ~req[i];
      end
      data_in = 40'({$urandom(), $urandom()});
      #1;
      check_model();
      if ($urandom_range(199) == 0) begin
        mid_reset(req);
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
